// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: default memory map bounds,
// MMIO register word offsets, STAT bit positions and the address region
// decoder used by the top level.
package mem_responder_pkg;

    localparam int          ROM_WORDS_DEF = 256;
    localparam int          MEM_WORDS_DEF = 8192;
    localparam logic [15:0] MMIO_BASE_DEF = 16'hFF00;
    localparam int          MMIO_BYTES    = 16;

    // MMIO registers are selected by RAMaddr[3:1] (byte offsets 0, 2, 4)
    localparam logic [2:0] MMIO_DATA = 3'd0;
    localparam logic [2:0] MMIO_STAT = 3'd1;
    localparam logic [2:0] MMIO_CTRL = 3'd2;

    localparam int STAT_RX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_OVERRUN  = 2;

    typedef enum logic [1:0] {
        REGION_ROM,
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_t;

    // Bounds are compared as 32-bit values so a backing store that reaches
    // the top of the 16-bit space cannot wrap.
    function automatic region_t decode_region(input logic [15:0] addr,
                                              input int          rom_words,
                                              input int          mem_words,
                                              input logic [15:0] mmio_base);
        int a;
        int b;
        a = int'({16'h0000, addr});
        b = int'({16'h0000, mmio_base});
        if (a >= b && a < b + MMIO_BYTES)
            return REGION_MMIO;
        else if (a < 2 * rom_words)
            return REGION_ROM;
        else if (a < 2 * mem_words)
            return REGION_RAM;
        else
            return REGION_NONE;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory bus between the CPU (master) and the memory responder
// (slave).
//   RAMaddr    byte address            RAMin      write data
//   we / re    write / read strobes    be         1 = byte access
//   RAMout     combinational read data page_fault one-cycle fault pulse
//   UART_intr  level UART rx interrupt
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [15:0] RAMaddr;
    logic [15:0] RAMin;
    logic        we;
    logic        re;
    logic        be;
    logic [15:0] RAMout;
    logic        page_fault;
    logic        UART_intr;

    modport master (
        output RAMaddr, RAMin, we, re, be,
        input  RAMout, page_fault, UART_intr
    );

    modport slave (
        input  RAMaddr, RAMin, we, re, be,
        output RAMout, page_fault, UART_intr
    );

endinterface

// File: rtl/mem_responder_uart_regs.sv
// UART register block behind the MMIO window: rx holding register with
// overrun tracking, tx holding register with ready/valid handshake, the
// rx interrupt enable and the registered interrupt output.
//   clk, reset      clock, synchronous active-high reset
//   data_wr/ctrl_wr qualified writes of wdata to DATA / CTRL
//   data_pop        qualified read of DATA (frees the rx holding register)
//   stat_rd         qualified read of STAT (clears overrun)
//   rx_data/valid   byte strobe from the receiver
//   tx_data/valid   tx holding register, consumed when tx_ready is high
//   rx_byte, rx_full, overrun, rx_ie   register contents for readback
//   uart_intr       rx_full & rx_ie, one cycle late
module uart_regs
    import mem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       data_wr,
    input  logic       data_pop,
    input  logic       stat_rd,
    input  logic       ctrl_wr,
    input  logic [7:0] wdata,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_full,
    output logic       overrun,
    output logic       rx_ie,
    output logic       uart_intr,
    output logic [7:0] tx_data,
    output logic       tx_valid
);

    // A new byte fits when the register is empty or is being popped now.
    logic rx_accept;
    assign rx_accept = rx_valid && (!rx_full || data_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_full   <= 1'b0;
            overrun   <= 1'b0;
            rx_ie     <= 1'b0;
            uart_intr <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            uart_intr <= rx_full & rx_ie;

            if (ctrl_wr)
                rx_ie <= wdata[0];

            if (rx_accept)
                rx_full <= 1'b1;
            else if (data_pop)
                rx_full <= 1'b0;

            // A dropped byte wins over a STAT read clearing in the same cycle.
            if (rx_valid && rx_full && !data_pop)
                overrun <= 1'b1;
            else if (stat_rd)
                overrun <= 1'b0;

            // A DATA write landing on the handshake cycle is dropped.
            if (tx_valid && tx_ready)
                tx_valid <= 1'b0;
            else if (data_wr && !tx_valid) begin
                tx_valid <= 1'b1;
                tx_data  <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rx_accept)
            rx_byte <= rx_data;
    end

endmodule

// File: rtl/mem_responder.sv
// Responder end of the CPU memory bus. Holds the backing word array (ROM
// region write-protected), decodes the address map, merges byte writes
// into words, serves zero-latency reads, pulses page_fault on the rising
// edge of an illegal access and fronts the UART registers in the MMIO
// window.
//   clk, reset             clock, synchronous active-high reset
//   bus (slave)            RAMaddr/RAMin/we/re/be in, RAMout/page_fault/
//                          UART_intr out
//   tx_data/tx_valid/tx_ready   byte stream to the UART transmitter
//   rx_data/rx_valid            byte strobe from the UART receiver
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          ROM_WORDS = ROM_WORDS_DEF,
    parameter int          MEM_WORDS = MEM_WORDS_DEF,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [15:0]      mem [MEM_WORDS];
    region_t          region;
    logic [IDX_W-1:0] idx;
    logic [15:0]      mem_word;
    logic [15:0]      mmio_word;
    logic [15:0]      sel_word;
    logic [15:0]      wr_word;
    logic             misaligned;
    logic             rd_err;
    logic             bad;
    logic             bad_q;
    logic             page_fault;
    logic             mem_wr;
    logic             mmio_wr_lo;
    logic             mmio_rd;
    logic             data_wr;
    logic             ctrl_wr;
    logic             data_pop;
    logic             stat_rd;
    logic [7:0]       rx_byte;
    logic             rx_full;
    logic             overrun;
    logic             rx_ie;
    logic             uart_intr;

    assign region     = decode_region(bus.RAMaddr, ROM_WORDS, MEM_WORDS, MMIO_BASE);
    assign idx        = bus.RAMaddr[IDX_W:1];
    assign mem_word   = mem[idx];
    assign misaligned = !bus.be && bus.RAMaddr[0];
    assign rd_err     = (region == REGION_NONE) || misaligned;
    assign bad        = (bus.we || bus.re) &&
                        (rd_err || (bus.we && region == REGION_ROM));

    // MMIO side effects only for legal accesses; writes need the low lane.
    assign mmio_wr_lo = bus.we && !bad && region == REGION_MMIO &&
                        (!bus.be || !bus.RAMaddr[0]);
    assign mmio_rd    = bus.re && !bad && region == REGION_MMIO;
    assign data_wr    = mmio_wr_lo && bus.RAMaddr[3:1] == MMIO_DATA;
    assign ctrl_wr    = mmio_wr_lo && bus.RAMaddr[3:1] == MMIO_CTRL;
    assign data_pop   = mmio_rd && bus.RAMaddr[3:1] == MMIO_DATA;
    assign stat_rd    = mmio_rd && bus.RAMaddr[3:1] == MMIO_STAT;
    assign mem_wr     = bus.we && !bad && region == REGION_RAM;

    always_comb begin
        mmio_word = 16'h0000;
        case (bus.RAMaddr[3:1])
            MMIO_DATA: mmio_word = {8'h00, rx_byte};
            MMIO_STAT: begin
                mmio_word[STAT_RX_FULL]  = rx_full;
                mmio_word[STAT_TX_EMPTY] = !tx_valid;
                mmio_word[STAT_OVERRUN]  = overrun;
            end
            MMIO_CTRL: mmio_word = {15'h0000, rx_ie};
            default:   mmio_word = 16'h0000;
        endcase
    end

    always_comb begin
        sel_word = 16'h0000;
        case (region)
            REGION_ROM, REGION_RAM: sel_word = mem_word;
            REGION_MMIO:            sel_word = mmio_word;
            default:                sel_word = 16'h0000;
        endcase
    end

    // Little endian: odd byte address selects the upper lane.
    always_comb begin
        if (rd_err)
            bus.RAMout = 16'h0000;
        else if (bus.be)
            bus.RAMout = {8'h00, bus.RAMaddr[0] ? sel_word[15:8] : sel_word[7:0]};
        else
            bus.RAMout = sel_word;
    end

    always_comb begin
        if (!bus.be)
            wr_word = bus.RAMin;
        else if (bus.RAMaddr[0])
            wr_word = {bus.RAMin[7:0], mem_word[7:0]};
        else
            wr_word = {mem_word[15:8], bus.RAMin[7:0]};
    end

    // Memory contents survive reset; a write coinciding with reset is lost.
    always_ff @(posedge clk) begin
        if (!reset && mem_wr)
            mem[idx] <= wr_word;
    end

    // Rising-edge detector: one pulse per run of consecutive bad cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_q      <= 1'b0;
            page_fault <= 1'b0;
        end else begin
            bad_q      <= bad;
            page_fault <= bad && !bad_q;
        end
    end

    assign bus.page_fault = page_fault;
    assign bus.UART_intr  = uart_intr;

    uart_regs u_uart_regs (
        .clk       (clk),
        .reset     (reset),
        .data_wr   (data_wr),
        .data_pop  (data_pop),
        .stat_rd   (stat_rd),
        .ctrl_wr   (ctrl_wr),
        .wdata     (bus.RAMin[7:0]),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_ready  (tx_ready),
        .rx_byte   (rx_byte),
        .rx_full   (rx_full),
        .overrun   (overrun),
        .rx_ie     (rx_ie),
        .uart_intr (uart_intr),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid)
    );

endmodule
